// File: rtl/fp10_pkg.sv
// Shared definitions for the 10-bit floating-point adder blocks.
// Word layout: sign [9], exponent [8:5], fraction [4:0].
package fp10_pkg;

    localparam int WIDTH    = 10;
    localparam int EXP_W    = 4;
    localparam int FRAC_W   = 5;
    localparam int SIGN_BIT = 9;
    localparam int EXP_MSB  = 8;
    localparam int EXP_LSB  = 5;

    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_Y  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    // Flush-to-zero: a zero exponent means zero, fraction ignored.
    function automatic logic is_zero(input word_t w);
        return w[EXP_MSB:EXP_LSB] == '0;
    endfunction

endpackage

// File: rtl/fp_add_sequencer_if.sv
// Operand stream, adder bus and result stream of the sequencer.
// master = sequencer side, slave = surrounding environment.
interface fp_add_sequencer_if;
    import fp10_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    word_t add_x;
    word_t add_y;
    word_t add_result;
    logic  add_overflow;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;
    logic  out_overflow;
    logic  out_bypass;

    modport master (
        input  in_valid, in_data, add_result, add_overflow, out_ready,
        output in_ready, add_x, add_y, out_valid, out_data,
        output out_overflow, out_bypass
    );

    modport slave (
        output in_valid, in_data, add_result, add_overflow, out_ready,
        input  in_ready, add_x, add_y, out_valid, out_data,
        input  out_overflow, out_bypass
    );

endinterface

// File: rtl/fp_zero_detect.sv
// Zero flags for an operand pair and the sum that results when
// either operand is zero, so the adder can be skipped.
module fp_zero_detect
    import fp10_pkg::*;
(
    input  word_t x,
    input  word_t y,
    output logic  x_zero,
    output logic  y_zero,
    output word_t bypass_word
);

    // Zero flags and the bypass sum; two zeros keep a negative sign
    // only when both operands are negative.
    always_comb begin
        x_zero      = is_zero(x);
        y_zero      = is_zero(y);
        bypass_word = x;
        if (x_zero && y_zero) begin
            bypass_word           = '0;
            bypass_word[SIGN_BIT] = x[SIGN_BIT] & y[SIGN_BIT];
        end else if (x_zero) begin
            bypass_word = y;
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Pairs serial operands, drives the fixed-latency adder and returns
// its sum, skipping the adder when an operand is zero.
module fp_add_sequencer
    import fp10_pkg::*;
#(
    parameter int LATENCY = 6,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    fp_add_sequencer_if.master bus
);

    state_t           state;
    state_t           state_nx;
    logic             ready_c;
    logic             xfer;
    word_t            x_hold;
    logic [CNT_W-1:0] cnt;
    logic             x_zero;
    logic             y_zero;
    word_t            bypass_word;

    fp_zero_detect u_zero (
        .x           (x_hold),
        .y           (bus.in_data),
        .x_zero      (x_zero),
        .y_zero      (y_zero),
        .bypass_word (bypass_word)
    );

    // Ready is masked during reset so nothing is taken in that window.
    assign bus.in_ready = ready_c & ~reset;
    assign xfer         = bus.in_valid & ready_c;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state decode and operand-side ready.
    always_comb begin
        state_nx = state;
        ready_c  = 1'b0;
        unique case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.in_valid) state_nx = GET_Y;
            end
            GET_Y: begin
                ready_c = 1'b1;
                if (bus.in_valid) begin
                    if (x_zero || y_zero) state_nx = RESULT;
                    else                  state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) state_nx = RESULT;
            end
            RESULT: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, latency counter and registered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_hold           <= '0;
            cnt              <= '0;
            bus.add_x        <= '0;
            bus.add_y        <= '0;
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.out_overflow <= 1'b0;
            bus.out_bypass   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) x_hold <= bus.in_data;
                end
                GET_Y: begin
                    if (xfer) begin
                        if (x_zero || y_zero) begin
                            bus.out_data     <= bypass_word;
                            bus.out_overflow <= 1'b0;
                            bus.out_bypass   <= 1'b1;
                            bus.out_valid    <= 1'b1;
                        end else begin
                            bus.add_x <= x_hold;
                            bus.add_y <= bus.in_data;
                            cnt       <= CNT_W'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bus.out_data     <= bus.add_result;
                        bus.out_overflow <= bus.add_overflow;
                        bus.out_bypass   <= 1'b0;
                        bus.out_valid    <= 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.out_ready) bus.out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer with a constant-output adder stub.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fp_add_sequencer;
    import fp10_pkg::*;

    localparam int LAT = 6;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    fp_add_sequencer_if bus ();

    fp_add_sequencer #(.LATENCY(LAT), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input word_t w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input word_t d,
                           input logic ov, input logic bp);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
        chk({tag, "_ovf"}, 32'(bus.out_overflow), 32'(ov));
        chk({tag, "_byp"}, 32'(bus.out_bypass), 32'(bp));
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.add_result   = 10'h120;
        bus.add_overflow = 1'b0;
        bus.out_ready    = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_add_x", 32'(bus.add_x), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Normal add through the adder
        step();
        send(10'h100);
        chk("add_get_y_ready", 32'(bus.in_ready), 32'd1);
        send(10'h0E0);
        chk("add_wait_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 1; i < LAT; i++) begin
            chk("add_x_hold", 32'(bus.add_x), 32'h100);
            chk("add_y_hold", 32'(bus.add_y), 32'h0E0);
            chk("add_no_early", 32'(bus.out_valid), 32'd0);
            step();
        end
        chk("add_x_last", 32'(bus.add_x), 32'h100);
        chk("add_no_early_last", 32'(bus.out_valid), 32'd0);
        step();
        chk_out("add", 10'h120, 1'b0, 1'b0);
        step();
        chk("add_drained", 32'(bus.out_valid), 32'd0);
        chk("add_idle_ready", 32'(bus.in_ready), 32'd1);

        // Bypass: x zero
        send(10'h000);
        send(10'h1A5);
        chk_out("byp", 10'h1A5, 1'b0, 1'b1);
        chk("byp_add_x", 32'(bus.add_x), 32'h100);
        chk("byp_add_y", 32'(bus.add_y), 32'h0E0);
        step();
        chk("byp_drained", 32'(bus.out_valid), 32'd0);

        // Both zero, both negative
        send(10'h200);
        send(10'h21F);
        chk_out("zz_neg", 10'h200, 1'b0, 1'b1);
        step();

        // Both zero, mixed sign
        send(10'h200);
        send(10'h01F);
        chk_out("zz_mix", 10'h000, 1'b0, 1'b1);
        step();

        // Backpressure with overflow
        bus.add_result   = 10'h155;
        bus.add_overflow = 1'b1;
        bus.out_ready    = 1'b0;
        send(10'h100);
        send(10'h100);
        for (int i = 0; i < LAT; i++) step();
        chk_out("bp", 10'h155, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 10'h3FF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out("bp_hold", 10'h155, 1'b1, 1'b0);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_hs_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("bp_released", 32'(bus.out_valid), 32'd0);
        chk("bp_idle_ready", 32'(bus.in_ready), 32'd1);

        // Input stall pattern 1,0,0,1 then pulses during WAIT
        bus.add_result   = 10'h120;
        bus.add_overflow = 1'b0;
        send(10'h140);
        step();
        step();
        chk("stall_ready", 32'(bus.in_ready), 32'd1);
        chk("stall_no_out", 32'(bus.out_valid), 32'd0);
        send(10'h0C0);
        chk("stall_add_x", 32'(bus.add_x), 32'h140);
        chk("stall_add_y", 32'(bus.add_y), 32'h0C0);
        for (int i = 1; i < LAT; i++) begin
            bus.in_valid = i[0];
            bus.in_data  = 10'h3FF;
            step();
        end
        bus.in_valid = 1'b0;
        chk("stall_x_kept", 32'(bus.add_x), 32'h140);
        chk("stall_y_kept", 32'(bus.add_y), 32'h0C0);
        chk("stall_no_early", 32'(bus.out_valid), 32'd0);
        step();
        chk_out("stall", 10'h120, 1'b0, 1'b0);
        step();
        chk("stall_idle", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset mid-WAIT with counter at 3
        bus.add_result   = 10'h2AA;
        bus.add_overflow = 1'b1;
        send(10'h100);
        send(10'h100);
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_add_x", 32'(bus.add_x), 32'd0);
        chk("ar_add_y", 32'(bus.add_y), 32'd0);
        chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_out_data", 32'(bus.out_data), 32'd0);
        chk("ar_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("ar_rel_ready", 32'(bus.in_ready), 32'd1);
        bus.add_result   = 10'h120;
        bus.add_overflow = 1'b0;
        send(10'h100);
        send(10'h100);
        for (int i = 1; i < LAT; i++) begin
            chk("ar_no_stale", 32'(bus.out_valid), 32'd0);
            step();
        end
        chk("ar_no_stale_last", 32'(bus.out_valid), 32'd0);
        step();
        chk_out("ar_fresh", 10'h120, 1'b0, 1'b0);
        step();
        chk("ar_drained", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Upstream operand sequencer for the 10-bit floating-point adder datapath.
- Accepts a serial valid/ready stream of operands and pairs them, first word as x and second as y.
- Drives x and y to the adder and holds them stable for the adder's fixed latency.
- Captures the result and overflow flag and presents them on a valid/ready output; zero operands bypass the adder.

Parameters:
- WIDTH, 10, total word width (sign + exponent + fraction)
- EXP_W, 4, exponent field width, bits [8:5]
- FRAC_W, 5, fraction field width, bits [4:0]
- LATENCY, 6, adder cycles from stable x/y to valid result; legal range 1..15
- CNT_W, 4, latency counter width; must satisfy 2^CNT_W > LATENCY

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data holds an operand
- in_ready  output  1  sequencer accepts an operand this cycle
- in_data  input  WIDTH  operand word: sign [9], exponent [8:5], fraction [4:0]
- add_x  output  WIDTH  operand x driven to the adder
- add_y  output  WIDTH  operand y driven to the adder
- add_result  input  WIDTH  adder rounding output
- add_overflow  input  1  adder overflow flag
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  sum
- out_overflow  output  1  overflow for this sum
- out_bypass  output  1  sum produced without the adder (zero operand)

Behaviour:
- Reset (asynchronous, active-high), applied at any time including mid-operation:
  - state=IDLE; add_x, add_y, out_data, counter = 0; out_valid, out_overflow, out_bypass = 0.
  - in_ready=0 while reset is asserted and 1 in the first cycle after release.
  - Any partially collected pair is discarded.
- States: IDLE, GET_Y, WAIT, RESULT.
- in_ready=1 only in IDLE and GET_Y. A transfer occurs when in_valid&&in_ready at a rising edge.
- IDLE: on transfer, latch in_data into x_hold and go to GET_Y.
- GET_Y: on transfer, compute zero flags. An operand is zero when exponent==0, fraction ignored (flush-to-zero).
  - Neither operand zero: add_x<=x_hold, add_y<=in_data, counter<=LATENCY, go to WAIT.
  - Exactly one operand zero: out_data<=the other operand unchanged, out_overflow<=0, out_bypass<=1, out_valid<=1, go to RESULT. add_x/add_y keep their previous values.
  - Both operands zero: out_data<=0, with sign = x sign AND y sign. Bypass and state as above.
- WAIT:
  - add_x/add_y held constant for the whole state.
  - counter decrements each cycle.
  - At the edge where counter==1: out_data<=add_result, out_overflow<=add_overflow, out_bypass<=0, out_valid<=1, go to RESULT.
  - out_valid therefore rises exactly LATENCY cycles after the y-accept edge.
  - in_valid is ignored and no operand is accepted.
- RESULT:
  - out_valid=1 and out_data/out_overflow/out_bypass stable until out_valid&&out_ready at an edge.
  - Then out_valid<=0 and go to IDLE.
  - No input overlap: in_ready stays 0 in the handshake cycle, and the next operand is accepted one cycle later at the earliest.
- out_ready is ignored outside RESULT.
- Throughput limits:
  - Adder path: one sum per LATENCY+3 cycles minimum.
  - Bypass path: one sum per 3 cycles minimum.
- All outputs are registered except in_ready, which decodes the state.
- No arithmetic is performed other than the counter decrement (CNT_W bits, never wraps) and the zero-sign AND.

Decomposition:
- Shared package, fp10_pkg:
  - constants WIDTH, EXP_W, FRAC_W, SIGN_BIT=9, EXP_MSB=8, EXP_LSB=5
  - state enum {IDLE, GET_Y, WAIT, RESULT}
  - function is_zero(word)
  - Reused by the adder-side blocks.
- Sub-module: fp_zero_detect (combinational). Drives zero flags for both operands and the bypass word/sign.
- The FSM and counter stay in fp_add_sequencer.

Test Plan:
- Normal add, bench adder stub with LATENCY=6 returning 10'h120 and overflow=0:
  - Stimulus: x=10'h100, y=10'h0E0, out_ready=1.
  - Required: add_x=10'h100 and add_y=10'h0E0 stable for 6 cycles; out_valid exactly 6 cycles after the y-accept edge; out_data=10'h120, out_bypass=0.
- Bypass, x=10'h000 and y=10'h1A5:
  - out_valid on the edge after y accept; out_data=10'h1A5, out_bypass=1.
  - Stub sees no change on add_x/add_y.
- Both zero, x=10'h200 (sign set) and y=10'h21F:
  - out_data=10'h200, out_bypass=1.
  - x=10'h200 with y=10'h01F: out_data=10'h000.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in RESULT with stub overflow=1.
  - out_valid, out_data and out_overflow=1 stay stable; in_ready=0 throughout; release gives IDLE one cycle later.
- Input stall: in_valid toggles 1,0,0,1.
  - Exactly two words are accepted; in_valid pulses during WAIT are ignored.
- Reset mid-WAIT (counter=3):
  - All outputs go to 0 immediately, asynchronously.
  - After release, a fresh pair 10'h100/10'h100 completes normally with no stale result.
